instr_mem_loader: RTL and testbench

Write-side companion to the instruction memory: receives a program as a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them into instruction memory through its write port. Holds the CPU in reset while loading, so the fetch path only ever reads a complete program. Sits between the host/UART byte source and the instruction memory write port.

---
 rtl/loader_pkg.sv | 17 +
 rtl/byte_packer.sv | 35 +++
 rtl/instr_mem_loader.sv | 152 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StData,
    StWrite,
    StChk,
    StDone
  } loader_state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles BYTES_PER_WORD stream bytes into one little-endian word.
module byte_packer
  import loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        accept,
  input  logic [7:0]                  byte_in,
  output logic [8*BYTES_PER_WORD-1:0] word,
  output logic                        last_lane
);

  localparam int unsigned LaneW = $clog2(BYTES_PER_WORD);

  logic [LaneW-1:0]            lane_q;
  logic [8*BYTES_PER_WORD-1:0] word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (clear) begin
      lane_q <= '0;
    end else if (accept) begin
      lane_q <= lane_q + LaneW'(1);
      // Shift in from the top so the first byte lands in lane 0.
      word_q <= {byte_in, word_q[8*BYTES_PER_WORD-1:8]};
    end
  end

  assign word      = word_q;
  assign last_lane = (lane_q == LaneW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader writing 32-bit words into instruction memory.
// Define LOADER_CHECKSUM_EN to add the trailing XOR checksum byte and error flag.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'hBFC00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             we,
  output logic [WIDTH-1:0] waddr,
  output logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             error
);

  loader_state_t state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic [15:0]      idx_q, idx_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             done_q, done_d;
  logic             accept, pk_clear, last_lane, to_final;
  logic [8*BYTES_PER_WORD-1:0] word;

  assign accept = byte_valid && byte_ready;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .accept    (accept && (state_q == StData)),
    .byte_in   (byte_in),
    .word      (word),
    .last_lane (last_lane)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    done_d     = done_q;
    byte_ready = 1'b0;
    we         = 1'b0;
    busy       = 1'b1;
    pk_clear   = 1'b0;
    to_final   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        busy = 1'b0;
        if (start) begin
          state_d  = StHdr0;
          done_d   = 1'b0;
          pk_clear = 1'b1;
        end
      end
      StHdr0: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          count_d[7:0] = byte_in;
          state_d      = StHdr1;
        end
      end
      StHdr1: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          count_d[15:8] = byte_in;
          idx_d         = '0;
          addr_d        = BASE_ADDR;
          if ({byte_in, count_q[7:0]} == 16'd0) to_final = 1'b1;
          else                                  state_d  = StData;
        end
      end
      StData: begin
        byte_ready = 1'b1;
        if (byte_valid && last_lane) state_d = StWrite;
      end
      StWrite: begin
        we     = 1'b1;
        idx_d  = idx_q + 16'd1;
        addr_d = addr_q + WIDTH'(BYTES_PER_WORD);
        if (idx_q == count_q - 16'd1) to_final = 1'b1;
        else                          state_d  = StData;
      end
      StChk: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (to_final) begin
`ifdef LOADER_CHECKSUM_EN
      state_d = StChk;
`else
      state_d = StDone;
      done_d  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign waddr = addr_q;
  assign wdata = WIDTH'(word);
  assign done  = done_q;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xor_q   <= '0;
      error_q <= 1'b0;
    end else if (start && (state_q == StIdle || state_q == StDone)) begin
      xor_q   <= '0;
      error_q <= 1'b0;
    end else if (accept) begin
      if (state_q == StChk) error_q <= (byte_in != xor_q);
      else                  xor_q   <= xor_q ^ byte_in;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader with a word-list reference model.
module tb_instr_mem_loader;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid, byte_ready, we, busy, done, error;
  logic [7:0]  byte_in;
  logic [31:0] waddr, wdata;

  always #5 clk = ~clk;

  instr_mem_loader #(.WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write the DUT issues must match the next expected (addr, data).
  always @(negedge clk) begin
    wr_t e;
    if (we === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_we", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("waddr", {32'd0, waddr}, {32'd0, e.addr});
        check("wdata", {32'd0, wdata}, {32'd0, e.data});
      end
    end
  end

  task automatic build(input logic [31:0] words[$], input bit corrupt, output logic [7:0] s[$]);
    logic [15:0] n;
    logic [7:0]  x;
    n = 16'(words.size());
    s = {};
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    foreach (words[i]) for (int b = 0; b < 4; b++) s.push_back(words[i][8*b +: 8]);
    x = 8'h00;
    foreach (s[k]) x = x ^ s[k];
`ifdef LOADER_CHECKSUM_EN
    s.push_back(x ^ {7'd0, corrupt});
`else
    if (corrupt && x == 8'hxx) $display("unreachable");
`endif
  endtask

  task automatic expect_words(input logic [31:0] words[$], input int count);
    wr_t e;
    for (int i = 0; i < count; i++) begin
      e.addr = BASE + 32'(4 * i);
      e.data = words[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_busy", {63'd0, busy}, 64'd1);
    check("start_ready", {63'd0, byte_ready}, 64'd1);
    check("start_done_clr", {63'd0, done}, 64'd0);
    check("start_err_clr", {63'd0, error}, 64'd0);
  endtask

  task automatic send_bytes(input logic [7:0] s[$], input int n_words, input int n_send,
                            input int gap_pct);
    int j = 0;
    int budget = 0;
    bit chk_we = 1'b0;
    bit rdy;
    while (j < n_send) begin
      @(negedge clk);
      #1;
      if (chk_we) begin
        check("we_after_lane3", {63'd0, we}, 64'd1);
        check("bubble_ready", {63'd0, byte_ready}, 64'd0);
        chk_we = 1'b0;
      end
      if (int'($urandom_range(99)) < gap_pct) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_in    = s[j];
      end
      #1 rdy = byte_ready;
      @(posedge clk);
      if (byte_valid && rdy) begin
        if (j >= 2 && j < 2 + 4 * n_words && (j - 2) % 4 == 3) chk_we = 1'b1;
        j++;
      end
      budget++;
      if (budget > 5000) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    #1;
    if (chk_we) begin
      check("we_after_lane3", {63'd0, we}, 64'd1);
      check("bubble_ready", {63'd0, byte_ready}, 64'd0);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (done !== 1'b1 && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("done", {63'd0, done}, 64'd1);
    check("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic full_load(input logic [31:0] words[$], input int gap_pct, input bit corrupt);
    logic [7:0] s[$];
    bit exp_err;
    build(words, corrupt, s);
    expect_words(words, words.size());
    do_start();
    send_bytes(s, words.size(), s.size(), gap_pct);
    wait_done();
`ifdef LOADER_CHECKSUM_EN
    exp_err = corrupt;
`else
    exp_err = 1'b0;
`endif
    check("error", {63'd0, error}, {63'd0, exp_err});
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] words[$];
    logic [7:0]  s[$];
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, byte_ready}, 64'd0);
    check("rst_we", {63'd0, we}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_waddr", {32'd0, waddr}, 64'd0);
    check("rst_wdata", {32'd0, wdata}, 64'd0);
    rst = 1'b0;

    // Idle with no start: nothing moves; the monitor flags any stray write.
    repeat (10) @(negedge clk);
    #1;
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_ready", {63'd0, byte_ready}, 64'd0);

    words = '{32'h00000513, 32'h00100293};
    full_load(words, 0, 1'b0);
    full_load(words, 50, 1'b0);

    words = {};
    full_load(words, 0, 1'b0);

    // Reset after six data bytes: only word 0 has been written.
    words = '{32'($urandom), 32'($urandom)};
    build(words, 1'b0, s);
    expect_words(words, 1);
    do_start();
    send_bytes(s, 2, 8, 0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_ready", {63'd0, byte_ready}, 64'd0);
    check("midrst_waddr", {32'd0, waddr}, 64'd0);
    check("midrst_wdata", {32'd0, wdata}, 64'd0);
    check("midrst_writes", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    full_load(words, 30, 1'b0);

    for (int r = 0; r < 6; r++) begin
      words = {};
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) words.push_back(32'($urandom));
      full_load(words, 40, r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
